issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Dual-issue hazard controller between fetch and `decode_unit`. Each cycle it takes up to two in-order instruction slots from fetch and tracks in-flight destination registers in an 8-entry scoreboard. It decides which slots may issue to decode/execute, or whether none may. It registers the issued pair, releases scoreboard entries on writeback, and squashes the registered pair on a taken branch.

## Interface
Parameters:
- `WB_MASK`, 16'h0FFE: bit i set means opcode i writes `rd`.
- `BR_MASK`, 16'hC000: bit i set means opcode i is branch-class; no slot may pair after it.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: downstream stall; hold issue registers.
- `is_branch_taken` in 1: flush of younger instructions.
- `instr0`, `instr1` in 16: fetch slots; slot0 is older.
- `valid0`, `valid1` in 1: slot valid; `valid1` is ignored unless `valid0`=1.
- `wbval0`, `wbval1` in 20: writeback ports. Bit19=0 means valid, [18:3] is the value (unused here), [2:0] is the register.
- `accept0`, `accept1` out 1: combinational; fetch may drop the slot at this edge.
- `issue_instr0`, `issue_instr1` out 16: registered issued instructions.
- `issue_valid0`, `issue_valid1` out 1: registered.
- `busy` out 8: scoreboard state, one bit per register.
- `hazard_stall_count` out 16: saturating count of hazard-stall cycles.

## Operation
- Fields: opcode [15:12], imm flag [11], rd [10:8], rs1 [7:5], rs2 [4:2].
- Opcode 0 is a NOP: no reads, no write.
- Any other opcode reads rs1. It also reads rs2 when imm=0. It writes rd when `WB_MASK[opcode]`=1.
- Effective busy (`ebusy`) = `busy` with this cycle's valid writeback registers cleared. A writeback bypasses within the same cycle.
- Slot0 hazard if either holds:
  - any read register is `ebusy`;
  - it writes and `ebusy[rd]` is set (WAW).
- `accept0` = `valid0` & !hazard0 & !`stall` & !`is_branch_taken`.
- `accept1` = `accept0` & `valid1` & !hazard1 & !`BR_MASK[op0]` & !intra-pair conflict. Hazard1 is computed against `ebusy` the same way as hazard0.
- Intra-pair conflict: slot0 writes, and slot1 reads rd0 or slot1 writes rd0.
- On each edge with no reset, no stall and no flush:
  - `issue_valid0` <= `accept0`; `issue_valid1` <= `accept1`.
  - `issue_instr` <= the accepted instruction, or 16'h0 if not accepted.
- Scoreboard update per edge:
  - `busy` <= `ebusy`;
  - then set rd of each accepted writing slot; set wins over a same-cycle clear;
  - on flush, additionally clear rd of each currently registered `issue_valid` slot that writes; flush clear wins over writeback;
  - on flush, no set occurs because accept=0.
- Flush edge: `issue_valid0/1` <= 0 and `issue_instr0/1` <= 0.
- Stall edge: issue registers hold; there is no set; writeback clears still apply.
- `hazard_stall_count` increments when `valid0` & hazard0 & !`stall` & !`is_branch_taken`, and saturates at 16'hFFFF.

## Timing
- Reset values: `busy`=0, `issue_valid0/1`=0, `issue_instr0/1`=16'h0, `hazard_stall_count`=0. `accept0/1`=0 while `reset`=1.
- Latency: slot accepted at edge N appears on `issue_*` after edge N; its `busy` bit is visible after edge N.
- Writeback at edge N: a dependent instruction presented in the same cycle is accepted at edge N (zero-bubble).
- `stall` and `is_branch_taken` both high: flush takes priority.
- Reset mid-operation: all state returns to reset values at the next edge, and in-flight `busy` is discarded.
- Both writeback ports naming the same register: a single clear.

## Test plan
- Reset, then `valid0`=1 with `instr0`=16'h114C (r1=r2+r3), and `valid1`=1 with `instr1`=16'h1A41 (r2=r2+1). Required: `accept0`=1 and `accept1`=0, because slot1 writes r2, which slot0 reads. Wait, that is not an intra-pair conflict, since rd0=r1. So the required result is `accept1`=1 and `busy` after the edge = 8'b0000_0110.
- With `busy[1]`=1, present `instr0`=16'h1434 (reads r1). Required: `accept0`=0 and `hazard_stall_count` increments each cycle. Then drive `wbval0`=20'h00001 (bit19=0, reg 1). Required: `accept0`=1 in that same cycle, and `busy` = 8'b0001_0000 after the edge.
- Pair 16'h114C + 16'h1434 (slot1 reads r1, written by slot0). Required: `accept0`=1, `accept1`=0; slot1 issues alone on the next cycle once r1 is written back.
- Issue 16'h114C; on the next cycle assert `is_branch_taken`. Required: `issue_valid0` goes 0, `busy[1]` goes 0, and `accept0/1`=0 during the flush cycle.
- Hold `stall`=1 for 3 cycles with a hazard-free pair. Required: `issue_*` holds, `accept0/1`=0, and the counter is unchanged. A writeback during the stall still clears its `busy` bit.
- Force 65 540 hazard cycles. Required: `hazard_stall_count` = 16'hFFFF and holds there.

Source files
------------

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - dual-issue hazard controller with an 8-register busy scoreboard
module issue_scoreboard #(
    parameter logic [15:0] WB_MASK = 16'h0FFE,
    parameter logic [15:0] BR_MASK = 16'hC000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_is_branch_taken,
    input  logic [15:0] i_instr0,
    input  logic [15:0] i_instr1,
    input  logic        i_valid0,
    input  logic        i_valid1,
    input  logic [19:0] i_wbval0,
    input  logic [19:0] i_wbval1,
    output logic        o_accept0,
    output logic        o_accept1,
    output logic [15:0] o_issue_instr0,
    output logic [15:0] o_issue_instr1,
    output logic        o_issue_valid0,
    output logic        o_issue_valid1,
    output logic [7:0]  o_busy,
    output logic [15:0] o_hazard_stall_count
);

    // Returns {write_set, read_set} as one-hot register masks for one instruction.
    function automatic logic [15:0] reg_sets(input logic [15:2] ins);
        logic [3:0] op;
        logic [7:0] rd_set;
        logic [7:0] wr_set;
        op     = ins[15:12];
        rd_set = 8'h00;
        wr_set = 8'h00;
        if (op != 4'h0) begin
            rd_set = 8'h01 << ins[7:5];
            if (!ins[11]) begin
                rd_set = rd_set | (8'h01 << ins[4:2]);
            end
            if (WB_MASK[op]) begin
                wr_set = 8'h01 << ins[10:8];
            end
        end
        return {wr_set, rd_set};
    endfunction

    function automatic logic [7:0] wb_clear(input logic [19:0] wb);
        return wb[19] ? 8'h00 : (8'h01 << wb[2:0]);
    endfunction

    logic [7:0]  r_busy;
    logic [15:0] r_issue_instr0;
    logic [15:0] r_issue_instr1;
    logic        r_issue_valid0;
    logic        r_issue_valid1;
    logic [15:0] r_hazard_cnt;

    logic [15:0] w_sets0;
    logic [15:0] w_sets1;
    logic [15:0] w_sets_iss0;
    logic [15:0] w_sets_iss1;
    logic [7:0]  w_rd0;
    logic [7:0]  w_wr0;
    logic [7:0]  w_rd1;
    logic [7:0]  w_wr1;
    logic [7:0]  w_wb_clr;
    logic [7:0]  w_ebusy;
    logic        w_haz0;
    logic        w_haz1;
    logic        w_pair_conf;
    logic        w_br0;
    logic        w_issue_ok;
    logic        w_accept0;
    logic        w_accept1;
    logic [7:0]  w_set;
    logic [7:0]  w_flush_clr;
    logic [7:0]  w_busy_next;
    logic        w_count_hazard;
    logic        w_unused_bits;

    assign w_unused_bits = ^{i_instr0[1:0], i_instr1[1:0], i_wbval0[18:3], i_wbval1[18:3],
                             w_sets_iss0[7:0], w_sets_iss1[7:0]};

    assign w_sets0     = reg_sets(i_instr0[15:2]);
    assign w_sets1     = reg_sets(i_instr1[15:2]);
    assign w_sets_iss0 = reg_sets(r_issue_instr0[15:2]);
    assign w_sets_iss1 = reg_sets(r_issue_instr1[15:2]);
    assign w_rd0       = w_sets0[7:0];
    assign w_wr0       = w_sets0[15:8];
    assign w_rd1       = w_sets1[7:0];
    assign w_wr1       = w_sets1[15:8];

    // Writebacks retire before hazard evaluation so a dependent instruction issues with no bubble.
    assign w_wb_clr = wb_clear(i_wbval0) | wb_clear(i_wbval1);
    assign w_ebusy  = r_busy & ~w_wb_clr;

    assign w_haz0      = |((w_rd0 | w_wr0) & w_ebusy);
    assign w_haz1      = |((w_rd1 | w_wr1) & w_ebusy);
    assign w_pair_conf = |(w_wr0 & (w_rd1 | w_wr1));
    assign w_br0       = BR_MASK[i_instr0[15:12]];

    assign w_issue_ok = !i_reset && !i_stall && !i_is_branch_taken;
    assign w_accept0  = i_valid0 && !w_haz0 && w_issue_ok;
    assign w_accept1  = w_accept0 && i_valid1 && !w_haz1 && !w_br0 && !w_pair_conf;

    assign w_set = (w_accept0 ? w_wr0 : 8'h00) | (w_accept1 ? w_wr1 : 8'h00);

    // A squashed pair never writes back, so its busy bits are released here instead.
    assign w_flush_clr = i_is_branch_taken ?
                         ((r_issue_valid0 ? w_sets_iss0[15:8] : 8'h00) |
                          (r_issue_valid1 ? w_sets_iss1[15:8] : 8'h00)) : 8'h00;

    assign w_busy_next    = (w_ebusy | w_set) & ~w_flush_clr;
    assign w_count_hazard = i_valid0 && w_haz0 && !i_stall && !i_is_branch_taken;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy         <= 8'h00;
            r_issue_instr0 <= 16'h0000;
            r_issue_instr1 <= 16'h0000;
            r_issue_valid0 <= 1'b0;
            r_issue_valid1 <= 1'b0;
            r_hazard_cnt   <= 16'h0000;
        end else begin
            r_busy <= w_busy_next;
            if (w_count_hazard && (r_hazard_cnt != 16'hFFFF)) begin
                r_hazard_cnt <= r_hazard_cnt + 16'h0001;
            end
            if (i_is_branch_taken) begin
                r_issue_instr0 <= 16'h0000;
                r_issue_instr1 <= 16'h0000;
                r_issue_valid0 <= 1'b0;
                r_issue_valid1 <= 1'b0;
            end else if (!i_stall) begin
                r_issue_instr0 <= w_accept0 ? i_instr0 : 16'h0000;
                r_issue_instr1 <= w_accept1 ? i_instr1 : 16'h0000;
                r_issue_valid0 <= w_accept0;
                r_issue_valid1 <= w_accept1;
            end
        end
    end

    assign o_accept0            = w_accept0;
    assign o_accept1            = w_accept1;
    assign o_issue_instr0       = r_issue_instr0;
    assign o_issue_instr1       = r_issue_instr1;
    assign o_issue_valid0       = r_issue_valid0;
    assign o_issue_valid1       = r_issue_valid1;
    assign o_busy               = r_busy;
    assign o_hazard_stall_count = r_hazard_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - scoreboard bench for issue_scoreboard against a register-level reference model
module tb_issue_scoreboard;

    localparam logic [15:0] TB_WB   = 16'h0FFE;
    localparam logic [15:0] TB_BR   = 16'hC000;
    localparam logic [19:0] WB_IDLE = 20'h80000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        is_branch_taken = 1'b0;
    logic [15:0] instr0 = 16'h0;
    logic [15:0] instr1 = 16'h0;
    logic        valid0 = 1'b0;
    logic        valid1 = 1'b0;
    logic [19:0] wbval0 = WB_IDLE;
    logic [19:0] wbval1 = WB_IDLE;
    logic        accept0, accept1, issue_valid0, issue_valid1;
    logic [15:0] issue_instr0, issue_instr1, hazard_stall_count;
    logic [7:0]  busy;

    always #5 clk = ~clk;

    issue_scoreboard #(.WB_MASK(TB_WB), .BR_MASK(TB_BR)) dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_is_branch_taken(is_branch_taken),
        .i_instr0(instr0), .i_instr1(instr1), .i_valid0(valid0), .i_valid1(valid1),
        .i_wbval0(wbval0), .i_wbval1(wbval1),
        .o_accept0(accept0), .o_accept1(accept1),
        .o_issue_instr0(issue_instr0), .o_issue_instr1(issue_instr1),
        .o_issue_valid0(issue_valid0), .o_issue_valid1(issue_valid1),
        .o_busy(busy), .o_hazard_stall_count(hazard_stall_count)
    );

    typedef struct {
        bit          a0, a1, iv0, iv1;
        logic [15:0] ii0, ii1, cnt;
        logic [7:0]  busy;
    } rec_t;

    rec_t q[$];
    int checks = 0;
    int failures = 0;

    bit          m_busy[8];
    bit          m_iv0, m_iv1;
    logic [15:0] m_ii0, m_ii1;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [15:0] ins, input int r);
        if (ins[15:12] == 4'h0) return 1'b0;
        if (int'(ins[7:5]) == r) return 1'b1;
        return !ins[11] && (int'(ins[4:2]) == r);
    endfunction

    function automatic bit writes(input logic [15:0] ins, input int r);
        if (ins[15:12] == 4'h0) return 1'b0;
        return (((TB_WB >> ins[15:12]) & 16'h1) != 16'h0) && (int'(ins[10:8]) == r);
    endfunction

    function automatic bit wb_hits(input logic [19:0] wb, input int r);
        return !wb[19] && (int'(wb[2:0]) == r);
    endfunction

    function automatic logic [19:0] wb(input int r);
        return {1'b0, 16'h0, 3'(r)};
    endfunction

    // Applies one cycle of the issue rules to the register-level model.
    task automatic model_step(output rec_t e);
        bit eff[8];
        bit h0, h1, conf, a0, a1, br0, nb;
        h0 = 0; h1 = 0; conf = 0; a0 = 0; a1 = 0;
        if (reset) begin
            for (int r = 0; r < 8; r++) m_busy[r] = 0;
            m_iv0 = 0; m_iv1 = 0; m_ii0 = 16'h0; m_ii1 = 16'h0; m_cnt = 0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                eff[r] = m_busy[r] && !wb_hits(wbval0, r) && !wb_hits(wbval1, r);
                if (eff[r] && (reads(instr0, r) || writes(instr0, r))) h0 = 1;
                if (eff[r] && (reads(instr1, r) || writes(instr1, r))) h1 = 1;
                if (writes(instr0, r) && (reads(instr1, r) || writes(instr1, r))) conf = 1;
            end
            br0 = ((TB_BR >> instr0[15:12]) & 16'h1) != 16'h0;
            a0 = valid0 && !h0 && !stall && !is_branch_taken;
            a1 = a0 && valid1 && !h1 && !br0 && !conf;
            for (int r = 0; r < 8; r++) begin
                nb = eff[r] || (a0 && writes(instr0, r)) || (a1 && writes(instr1, r));
                if (is_branch_taken && ((m_iv0 && writes(m_ii0, r)) || (m_iv1 && writes(m_ii1, r))))
                    nb = 0;
                m_busy[r] = nb;
            end
            if (valid0 && h0 && !stall && !is_branch_taken && m_cnt < 65535) m_cnt++;
            if (is_branch_taken) begin
                m_iv0 = 0; m_iv1 = 0; m_ii0 = 16'h0; m_ii1 = 16'h0;
            end else if (!stall) begin
                m_iv0 = a0; m_iv1 = a1;
                m_ii0 = a0 ? instr0 : 16'h0;
                m_ii1 = a1 ? instr1 : 16'h0;
            end
        end
        e.a0 = a0; e.a1 = a1; e.iv0 = m_iv0; e.iv1 = m_iv1;
        e.ii0 = m_ii0; e.ii1 = m_ii1; e.cnt = 16'(m_cnt);
        for (int r = 0; r < 8; r++) e.busy[r] = m_busy[r];
    endtask

    task automatic drive(input bit rs, input bit st, input bit br,
                         input logic [15:0] a, input bit va, input logic [15:0] b, input bit vb,
                         input logic [19:0] w0 = WB_IDLE, input logic [19:0] w1 = WB_IDLE);
        rec_t e;
        @(negedge clk);
        reset = rs; stall = st; is_branch_taken = br;
        instr0 = a; valid0 = va; instr1 = b; valid1 = vb;
        wbval0 = w0; wbval1 = w1;
        #1;
        model_step(e);
        q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        rec_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("accept0", accept0, e.a0);
                chk("accept1", accept1, e.a1);
                @(posedge clk);
                #1;
                chk("issue_valid0", issue_valid0, e.iv0);
                chk("issue_valid1", issue_valid1, e.iv1);
                chk("issue_instr0", issue_instr0, e.ii0);
                chk("issue_instr1", issue_instr1, e.ii1);
                chk("busy", busy, e.busy);
                chk("hazard_count", hazard_stall_count, e.cnt);
            end
        end
    end

    initial begin : stimulus
        logic [15:0] ra, rb;
        repeat (2) drive(1, 0, 0, 16'h0, 0, 16'h0, 0);
        after_edge();
        chk("rst_busy", busy, 8'h00);
        chk("rst_iv0", issue_valid0, 1'b0);
        chk("rst_cnt", hazard_stall_count, 16'h0);

        drive(0, 0, 0, 16'h114C, 1, 16'h1A41, 1);
        chk("tp1_acc0", accept0, 1'b1);
        chk("tp1_acc1", accept1, 1'b1);
        after_edge();
        chk("tp1_busy", busy, 8'b0000_0110);

        drive(0, 0, 0, 16'h0, 0, 16'h0, 0, wb(2));
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 16'h1434, 1, 16'h0, 0);
            chk("tp2_blocked", accept0, 1'b0);
        end
        after_edge();
        chk("tp2_cnt", hazard_stall_count, 16'd3);
        drive(0, 0, 0, 16'h1434, 1, 16'h0, 0, wb(1));
        chk("tp2_bypass", accept0, 1'b1);
        after_edge();
        chk("tp2_busy", busy, 8'b0001_0000);

        drive(0, 0, 0, 16'h0, 0, 16'h0, 0, wb(4));
        drive(0, 0, 0, 16'h114C, 1, 16'h1434, 1);
        chk("tp3_acc0", accept0, 1'b1);
        chk("tp3_acc1", accept1, 1'b0);
        drive(0, 0, 0, 16'h1434, 1, 16'h0, 0, wb(1));
        chk("tp3_next", accept0, 1'b1);
        after_edge();
        chk("tp3_issue", issue_instr0, 16'h1434);
        drive(0, 0, 0, 16'h0, 0, 16'h0, 0, wb(4));

        drive(0, 0, 0, 16'h114C, 1, 16'h0, 0);
        drive(0, 0, 1, 16'h2000, 1, 16'h2000, 1);
        chk("tp4_acc0", accept0, 1'b0);
        chk("tp4_acc1", accept1, 1'b0);
        after_edge();
        chk("tp4_iv0", issue_valid0, 1'b0);
        chk("tp4_busy1", busy[1], 1'b0);

        drive(0, 0, 0, 16'h1A41, 1, 16'h0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 16'h1360, 1, 16'h1580, 1, (i == 1) ? wb(2) : WB_IDLE);
            chk("tp5_acc0", accept0, 1'b0);
            after_edge();
            chk("tp5_hold", issue_instr0, 16'h1A41);
        end
        chk("tp5_busy", busy, 8'h00);
        chk("tp5_cnt", hazard_stall_count, 16'd3);
        drive(0, 0, 0, 16'h1360, 1, 16'h1580, 1);
        chk("tp5_acc1", accept1, 1'b1);

        drive(1, 0, 0, 16'h0, 0, 16'h0, 0);
        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                  ra, $urandom_range(0, 4) != 0, rb, $urandom_range(0, 4) != 0,
                  {1'($urandom_range(0, 1)), 16'h0, 3'($urandom_range(0, 7))},
                  {1'($urandom_range(0, 2) == 0), 16'h0, 3'($urandom_range(0, 7))});
        end

        drive(1, 0, 0, 16'h0, 0, 16'h0, 0);
        drive(0, 0, 0, 16'h114C, 1, 16'h0, 0);
        repeat (65540) drive(0, 0, 0, 16'h1434, 1, 16'h0, 0);
        after_edge();
        chk("sat_cnt", hazard_stall_count, 16'hFFFF);
        drive(0, 0, 0, 16'h1434, 1, 16'h0, 0);
        after_edge();
        chk("sat_hold", hazard_stall_count, 16'hFFFF);
        drive(1, 0, 0, 16'h0, 0, 16'h0, 0);
        after_edge();
        chk("rst_again", hazard_stall_count, 16'h0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
